// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, visible-area bounds and coordinate widths
// shared by the sync generator and the overlay stage.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned FRAME_W = 8;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Last visible coordinate on each axis.
    localparam int unsigned H_VIS_MAX = H_DISPLAY_DEF - 1;
    localparam int unsigned V_VIS_MAX = V_DISPLAY_DEF - 1;

    // True when lo <= c < lo+len.
    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(c) >= lo) && (32'(c) < (lo + len));
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-enable divider: p_tick is high one clk out of every CLK_DIV.
module vga_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_tick_div: CLK_DIV must be within 1..16");
    end

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Gated by rst so CLK_DIV=1 still reads 0 while held in reset.
    assign p_tick = !rst && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v counters, registered active-low syncs, video_on.
// Define VGA_SYNC_FRAME_CNT_EN to add the frame_tick / frame_cnt outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic               h_last;
    logic               v_last;
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               hsync_q;
    logic               vsync_q;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .p_tick (p_tick)
    );

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + COORD_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + COORD_W'(1);
            end
        end
    end

    // Syncs are decoded from the next-state counts to stay aligned with pixel_x/y.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= !in_window(h_cnt_d, HS_START, H_SYNC);
            vsync_q <= !in_window(v_cnt_d, VS_START, V_SYNC);
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign pixel_x  = h_cnt_q;
    assign pixel_y  = v_cnt_q;
    assign video_on = !rst && (h_cnt_q < COORD_W'(H_DISPLAY)) && (v_cnt_q < COORD_W'(V_DISPLAY));

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic               frame_wrap;
    logic               frame_tick_q;
    logic [FRAME_W-1:0] frame_cnt_q;

    assign frame_wrap = p_tick && h_last && v_last;

    // frame_tick lands on the same clk the counters show (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_tick_q <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;
`else
    // Frame counter not built.
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance (line timing) and a
// shrunken-raster instance with CLK_DIV=1 (frame timing, edges, resets).
module tb_vga_sync_gen;

    localparam int AD = 4, AHD = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVD = 480, AVF = 10, AVS = 2, AVB = 33;
    localparam int BD = 1, BHD = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVD = 6, BVF = 2, BVS = 2, BVB = 3;
    localparam int BHT = BHD + BHF + BHS + BHB;
    localparam int BVT = BVD + BVF + BVS + BVB;
    localparam int BFRAME = BHT * BVT * BD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       hsync_a, vsync_a, video_on_a, p_tick_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b;
    logic [9:0] pixel_x_b, pixel_y_b;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic       frame_tick_a, frame_tick_b;
    logic [7:0] frame_cnt_a, frame_cnt_b;
`endif

    int k_a = 0, k_b = 0;
    int errors = 0, checks = 0;

    vga_sync_gen dut_a (
        .clk(clk), .rst(rst_a), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a), .p_tick(p_tick_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_tick(frame_tick_a), .frame_cnt(frame_cnt_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(BD), .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) dut_b (
        .clk(clk), .rst(rst_b), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b), .p_tick(p_tick_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_tick(frame_tick_b), .frame_cnt(frame_cnt_b)
`endif
    );

    // Clocks elapsed since the last clk edge that sampled reset.
    always @(posedge clk) k_a <= rst_a ? 0 : k_a + 1;
    always @(posedge clk) k_b <= rst_b ? 0 : k_b + 1;

    // Expected {hsync, vsync, video_on, p_tick, x, y} after k clks out of reset.
    function automatic logic [23:0] model(input int k, input int d,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb);
        int ht, vt, n, x, y;
        logic hsy, vsy, von, pt;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        n   = k / d;
        x   = n % ht;
        y   = (n / ht) % vt;
        hsy = !(x >= hd + hf && x < hd + hf + hs);
        vsy = !(y >= vd + vf && y < vd + vf + vs);
        von = (x < hd) && (y < vd);
        pt  = (k % d) == (d - 1);
        return {hsy, vsy, von, pt, 10'(x), 10'(y)};
    endfunction

    function automatic logic [23:0] model_a(input int k);
        return model(k, AD, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB);
    endfunction

    function automatic logic [23:0] model_b(input int k);
        return model(k, BD, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB);
    endfunction

    task automatic test_reset();
        int cyc;
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({hsync_a, vsync_a, video_on_a, p_tick_a, pixel_x_a, pixel_y_a} !== {4'b1100, 20'd0}) begin
            errors++;
            $display("FAIL reset_a got=%h want=%h", {hsync_a, vsync_a, video_on_a, p_tick_a, pixel_x_a, pixel_y_a}, {4'b1100, 20'd0});
        end
        checks++;
        if ({hsync_b, vsync_b, video_on_b, p_tick_b, pixel_x_b, pixel_y_b} !== {4'b1100, 20'd0}) begin
            errors++;
            $display("FAIL reset_b got=%h want=%h", {hsync_b, vsync_b, video_on_b, p_tick_b, pixel_x_b, pixel_y_b}, {4'b1100, 20'd0});
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (p_tick_a !== 1'b1 && cyc < 20);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL first_p_tick got clk %0d want clk 4", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (p_tick_a !== 1'b1 && cyc < 20);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL p_tick_period got=%0d want=4", cyc);
            end
            checks++;
            if (p_tick_b !== 1'b1) begin
                errors++;
                $display("FAIL p_tick_div1_held got=%b want=1", p_tick_b);
            end
        end
    endtask

    task automatic test_line();
        int guard, lowcnt, period;
        logic prev;
        repeat ($urandom_range(0, 50)) @(negedge clk);
        for (int i = 0; i < 6700; i++) begin
            @(negedge clk);
            checks++;
            if ({hsync_a, vsync_a, video_on_a, p_tick_a, pixel_x_a, pixel_y_a} !== model_a(k_a)) begin
                errors++;
                $display("FAIL line_snapshot k=%0d got=%h want=%h", k_a, {hsync_a, vsync_a, video_on_a, p_tick_a, pixel_x_a, pixel_y_a}, model_a(k_a));
            end
        end
        guard = 0;
        prev = hsync_a;
        while (!(prev === 1'b1 && hsync_a === 1'b0) && guard < 4000) begin
            prev = hsync_a;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 4000 || pixel_x_a !== 10'd656) begin
            errors++;
            $display("FAIL hsync_start_x got=%0d want=656 (wait=%0d)", pixel_x_a, guard);
        end
        lowcnt = 0;
        period = 0;
        do begin
            if (hsync_a === 1'b0 && p_tick_a === 1'b1) lowcnt++;
            prev = hsync_a;
            @(negedge clk);
            period++;
        end while (!(prev === 1'b1 && hsync_a === 1'b0) && period < 4000);
        checks++;
        if (lowcnt != 96) begin
            errors++;
            $display("FAIL hsync_width got=%0d p_ticks want=96", lowcnt);
        end
        checks++;
        if (period != 3200) begin
            errors++;
            $display("FAIL line_period got=%0d clks want=3200", period);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (pixel_x_a !== 10'd700 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        checks++;
        if (guard >= 4000 || {hsync_a, vsync_a, pixel_x_a, pixel_y_a} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL mid_reset got=%h want=%h (wait=%0d)", {hsync_a, vsync_a, pixel_x_a, pixel_y_a}, {2'b11, 20'd0}, guard);
        end
        for (int i = 0; i < 3300 + int'($urandom_range(0, 200)); i++) begin
            @(negedge clk);
            checks++;
            if ({hsync_a, vsync_a, video_on_a, p_tick_a, pixel_x_a, pixel_y_a} !== model_a(k_a)) begin
                errors++;
                $display("FAIL resume_snapshot k=%0d got=%h want=%h", k_a, {hsync_a, vsync_a, video_on_a, p_tick_a, pixel_x_a, pixel_y_a}, model_a(k_a));
            end
        end
    endtask

    task automatic test_frame();
        int guard;
        for (int i = 0; i < 2 * BFRAME + int'($urandom_range(0, 60)); i++) begin
            @(negedge clk);
            checks++;
            if ({hsync_b, vsync_b, video_on_b, p_tick_b, pixel_x_b, pixel_y_b} !== model_b(k_b)) begin
                errors++;
                $display("FAIL frame_snapshot k=%0d got=%h want=%h", k_b, {hsync_b, vsync_b, video_on_b, p_tick_b, pixel_x_b, pixel_y_b}, model_b(k_b));
            end
        end
        guard = 0;
        while (!(pixel_x_b == 10'(BHT - 1) && pixel_y_b == 10'(BVT - 1)) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checks++;
        if (guard >= 1000 || {pixel_x_b, pixel_y_b} !== 20'd0) begin
            errors++;
            $display("FAIL y_wrap got=(%0d,%0d) want=(0,0)", pixel_x_b, pixel_y_b);
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(pixel_x_b == 10'd0 && pixel_y_b == 10'd0) && guard < 1000);
        checks++;
        if (guard != BFRAME) begin
            errors++;
            $display("FAIL frame_period got=%0d clks want=%0d", guard, BFRAME);
        end
    endtask

    task automatic test_visible();
        int   vx[4] = '{BHD - 1, BHD, 0, 0};
        int   vy[4] = '{BVD - 1, BVD - 1, BVD, 0};
        logic von[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   guard;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (!(pixel_x_b == 10'(vx[i]) && pixel_y_b == 10'(vy[i])) && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (guard >= 1000 || video_on_b !== von[i]) begin
                errors++;
                $display("FAIL visible_edge (%0d,%0d) got=%b want=%b", vx[i], vy[i], video_on_b, von[i]);
            end
        end
    endtask

    task automatic test_random_reset();
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            rst_b = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_b = 1'b0;
            checks++;
            if ({hsync_b, vsync_b, pixel_x_b, pixel_y_b} !== {2'b11, 20'd0}) begin
                errors++;
                $display("FAIL rand_reset got=%h want=%h", {hsync_b, vsync_b, pixel_x_b, pixel_y_b}, {2'b11, 20'd0});
            end
            for (int i = 0; i < int'($urandom_range(20, 250)); i++) begin
                @(negedge clk);
                checks++;
                if ({hsync_b, vsync_b, video_on_b, p_tick_b, pixel_x_b, pixel_y_b} !== model_b(k_b)) begin
                    errors++;
                    $display("FAIL rand_snapshot k=%0d got=%h want=%h", k_b, {hsync_b, vsync_b, video_on_b, p_tick_b, pixel_x_b, pixel_y_b}, model_b(k_b));
                end
            end
        end
    endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int   pulses, wide, guard;
        logic prev;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        pulses = 0;
        wide = 0;
        prev = frame_tick_b;
        for (int i = 0; i < 3 * BFRAME; i++) begin
            @(negedge clk);
            if (frame_tick_b === 1'b1) pulses++;
            if (frame_tick_b === 1'b1 && prev === 1'b1) wide++;
            prev = frame_tick_b;
        end
        checks++;
        if (pulses != 3 || wide != 0) begin
            errors++;
            $display("FAIL frame_tick_pulses got=%0d (wide=%0d) want=3 (wide=0)", pulses, wide);
        end
        checks++;
        if (frame_cnt_b !== 8'd3) begin
            errors++;
            $display("FAIL frame_cnt_3 got=%0d want=3", frame_cnt_b);
        end
        guard = 0;
        while (frame_cnt_b !== 8'd255 && guard < 256 * BFRAME) begin
            @(negedge clk);
            guard++;
        end
        do begin
            @(negedge clk);
            guard++;
        end while (frame_tick_b !== 1'b1 && guard < 257 * BFRAME);
        checks++;
        if (guard >= 257 * BFRAME || frame_cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap got=%0d want=0", frame_cnt_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_frame();
        test_visible();
        test_random_reset();
`ifdef VGA_SYNC_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
